// File: rtl/cla_seq_ctrl.sv
// rtl/cla_seq_ctrl.sv - nibble-serial add/subtract sequencer driving an external 4-bit CLA
module cla_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   sub,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic                   ovf,
   output logic [3:0]             cla_x,
   output logic [3:0]             cla_y,
   output logic                   cla_cin,
   input  logic [3:0]             cla_z,
   input  logic                   cla_cout
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;
   logic            carry;
   logic [IW-1:0]   idx;
   logic            accept;
   logic            last;

   assign accept = start && (state != S_RUN);
   assign last   = (idx == LAST);

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      cla_x    = 4'd0;
      cla_y    = 4'd0;
      cla_cin  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_RUN;
         end
         S_RUN: begin
            busy    = 1'b1;
            cla_x   = a_r[4*idx +: 4];
            cla_y   = b_r[4*idx +: 4];
            cla_cin = carry;
            if (last) state_nx = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = start ? S_RUN : S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Subtract is folded into acceptance: B is inverted here and the +1 rides in on carry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         a_r   <= '0;
         b_r   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            sum   <= '0;
         end else if (state == S_RUN) begin
            sum[4*idx +: 4] <= cla_z;
            carry           <= cla_cout;
            if (last) begin
               cout <= cla_cout;
               ovf  <= (a_r[W-1] == b_r[W-1]) && (cla_z[3] != a_r[W-1]);
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb/tb_cla_seq_ctrl.sv - directed and random checks of cla_seq_ctrl against an arithmetic model
module tb_cla_seq_ctrl;

   localparam int N = 4;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          sub;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  sum;
   logic          cout;
   logic          ovf;
   logic [3:0]    cla_x;
   logic [3:0]    cla_y;
   logic          cla_cin;
   logic [3:0]    cla_z;
   logic          cla_cout;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Behavioural stand-in for the combinational 4-bit adder.
   logic [4:0] cla_full;
   assign cla_full = {1'b0, cla_x} + {1'b0, cla_y} + {4'd0, cla_cin};
   assign cla_z    = cla_full[3:0];
   assign cla_cout = cla_full[4];

   cla_seq_ctrl #(.NIBBLES(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf),
      .cla_x    (cla_x),
      .cla_y    (cla_y),
      .cla_cin  (cla_cin),
      .cla_z    (cla_z),
      .cla_cout (cla_cout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                 output logic [W-1:0] ms_sum, output logic ms_cout, output logic ms_ovf);
      int sa, sb, r;
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      if (ms) begin
         ms_sum  = ma - mb;
         ms_cout = (ma >= mb);
         r       = sa - sb;
      end else begin
         ms_sum  = ma + mb;
         ms_cout = (int'(ma) + int'(mb)) > 65535;
         r       = sa + sb;
      end
      ms_ovf = (r > 32767) || (r < -32768);
   endfunction

   // Called at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle.
   task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                     input bit inject, output logic [3:0] cins);
      logic [W-1:0] e_sum;
      logic         e_cout, e_ovf;
      model(ta, tb, ts, e_sum, e_cout, e_ovf);
      start = 1'b1; a = ta; b = tb; sub = ts;
      for (int c = 1; c <= N; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
         end
         if (c == 2 && inject) start = 1'b1;
         if (c == 3) start = 1'b0;
         chk("run_busy", 32'(busy), 32'd1);
         chk("run_done", 32'(done), 32'd0);
         chk("run_cla_x", 32'(cla_x), 32'((ta >> (4*(c-1))) & 16'hF));
         cins[c-1] = cla_cin;
      end
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_cin_idle", 32'(cla_cin), 32'd0);
      chk("sum", 32'(sum), 32'(e_sum));
      chk("cout", 32'(cout), 32'(e_cout));
      chk("ovf", 32'(ovf), 32'(e_ovf));
   endtask

   task automatic idle_check(input logic [W-1:0] held);
      @(negedge clk);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_sum_held", 32'(sum), 32'(held));
   endtask

   initial begin
      logic [3:0] cins;
      logic [W-1:0] ra, rb;
      logic rs;
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
      chk("rst_cla", {23'd0, cla_x, cla_y, cla_cin}, 32'd0);

      op(16'h1234, 16'h4321, 1'b0, 1'b0, cins);
      chk("add_cins", 32'(cins), 32'h0);
      chk("add_sum_const", 32'(sum), 32'h5555);
      idle_check(16'h5555);

      op(16'hFFFF, 16'h0001, 1'b0, 1'b0, cins);
      chk("ripple_cins", 32'(cins), 32'hE);
      idle_check(16'h0000);

      op(16'h7FFF, 16'h0001, 1'b0, 1'b0, cins);
      chk("ovf_const", {15'd0, sum, cout, ovf}, {15'd0, 16'h8000, 1'b0, 1'b1});
      idle_check(16'h8000);

      op(16'h0005, 16'h0007, 1'b1, 1'b0, cins);
      chk("sub1_cin0", 32'(cins[0]), 32'd1);
      chk("sub1_const", {15'd0, sum, cout, ovf}, {15'd0, 16'hFFFE, 1'b0, 1'b0});
      idle_check(16'hFFFE);

      // Start injected mid-RUN must be ignored; start in DONE chains immediately.
      op(16'h8000, 16'h0001, 1'b1, 1'b1, cins);
      chk("sub2_cin0", 32'(cins[0]), 32'd1);
      chk("sub2_const", {15'd0, sum, cout, ovf}, {15'd0, 16'h7FFF, 1'b1, 1'b1});
      op(16'h0001, 16'h0001, 1'b0, 1'b0, cins);
      chk("chain_sum", 32'(sum), 32'h0002);
      op(16'h8000, 16'h0001, 1'b1, 1'b0, cins);

      // Reset in cycle 3 of an add: outputs return to reset values, no done.
      start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_outs", {15'd0, sum, cout, ovf}, 32'd0);
      chk("mid_rst_cla", {23'd0, cla_x, cla_y, cla_cin}, 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("mid_rst_nodone", 32'(done), 32'd0);
      end
      op(16'h1111, 16'h2222, 1'b0, 1'b0, cins);
      idle_check(16'h3333);

      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
         if (i % 6 == 0) rb = ra;
         op(ra, rb, rs, 1'($urandom), cins);
         chk("rand_cin0", 32'(cins[0]), 32'(rs));
         if ($urandom_range(0, 2) == 0) idle_check(sum);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cla_seq_ctrl.md
# cla_seq_ctrl

Nibble-serial multi-precision add/subtract sequencer for the 4-bit carry-lookahead adder (`cla`). It latches two `4*NIBBLES`-bit operands on a start handshake and drives one external `cla` instance one nibble per cycle, LSB first. It carries the rippled carry between cycles in a register, assembles the result, and reports carry-out and signed overflow. It sits between a requester (ALU/register-file sequencer) and a single shared `cla` datapath.

## Interface

Parameters:
- `NIBBLES`, 4, operand width in nibbles (≥2); operand width `W = 4*NIBBLES`.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous active-high reset.
- `start` input 1: operation request; accepted only when `busy=0`.
- `sub` input 1: 0 = A+B, 1 = A−B; sampled with `start`.
- `a` input W: operand A; sampled with `start`.
- `b` input W: operand B; sampled with `start`.
- `busy` output 1: high while sequencing (RUN state).
- `done` output 1: one-cycle pulse when the result is valid.
- `sum` output W: result register.
- `cout` output 1: final carry (for subtract, 1 = no borrow).
- `ovf` output 1: two's-complement overflow.
- `cla_x` output 4: to `cla` x4..x1 (bit 0 = x1).
- `cla_y` output 4: to `cla` y4..y1.
- `cla_cin` output 1: to `cla` cin.
- `cla_z` input 4: from `cla` z4..z1.
- `cla_cout` input 1: from `cla` cout.

## Operation

- States: IDLE, RUN, DONE. Registers: `a_r`, `b_r` (W), `sub_r`, `carry`, `idx` (clog2 NIBBLES), `sum`, `cout`, `ovf`.
- Acceptance: in IDLE or DONE, `start=1` means:
  - `a_r<=a`; `b_r<=b` if `sub=0`, else `b_r<=~b`.
  - `sub_r<=sub`; `carry<=sub`; `idx<=0`; `sum<=0`; next state RUN.
- `start` in RUN is ignored; there is no queuing.
- RUN, combinational drive:
  - `cla_x = a_r[4*idx+:4]`
  - `cla_y = b_r[4*idx+:4]`
  - `cla_cin = carry`
- RUN, at each edge: `sum[4*idx+:4]<=cla_z`; `carry<=cla_cout`; `idx<=idx+1`.
- When `idx==NIBBLES-1`, next state is DONE and the following also update at that edge:
  - `cout<=cla_cout`
  - `ovf<=(a_r[W-1]==b_r[W-1]) && (cla_z[3]!=a_r[W-1])`
- DONE: `done=1` for exactly this cycle. Next state is IDLE unless `start` is accepted, in which case it is RUN.
- Outside RUN, `cla_x`, `cla_y`, `cla_cin` are driven 0.
- `sum`, `cout`, `ovf` are valid from the DONE cycle and held until the next accepted `start`.
  - `sum` clears at acceptance.
  - `cout` and `ovf` hold until overwritten at the next final nibble.
- Arithmetic is modulo 2^W. Subtract is A + ~B + 1, with the +1 supplied through the initial `carry`.

## Timing

- Reset values: state IDLE, `busy=0`, `done=0`, `sum=0`, `cout=0`, `ovf=0`, `cla_x=0`, `cla_y=0`, `cla_cin=0`, `carry=0`, `idx=0`.
- `rst` overrides every other input on the same edge.
- Reset mid-RUN aborts the operation: no `done` is produced and outputs return to reset values.
- Latency, with `start` sampled at edge 0:
  - RUN occupies cycles 1..NIBBLES, so `busy=1` for exactly NIBBLES cycles.
  - `done=1` in cycle NIBBLES+1.
- Throughput: back-to-back operations are possible. A `start` in the DONE cycle begins RUN in the next cycle, giving one op per NIBBLES+1 cycles.
- `busy` and `done` are never high simultaneously.
- `cla` is purely combinational. The `cla_z`/`cla_cout` path must settle within one cycle, and the controller adds no pipeline stage.
- `idx` wrap: `idx` never exceeds NIBBLES-1. It is reset to 0 on acceptance, and its value in IDLE/DONE is don't-care but held.

## Test plan

All scenarios use NIBBLES=4.
- Basic add: A=0x1234, B=0x4321, sub=0 → `done` in cycle 5 with `sum`=0x5555, `cout`=0, `ovf`=0; `busy` high in cycles 1–4 only; `cla_cin` = 0,0,0,0.
- Full carry ripple: 0xFFFF + 0x0001 → `sum`=0x0000, `cout`=1, `ovf`=0; `cla_cin` sequence per RUN cycle = 0,1,1,1.
- Signed overflow: 0x7FFF + 0x0001 → `sum`=0x8000, `ovf`=1, `cout`=0.
- Subtract:
  - 0x0005 − 0x0007 → `sum`=0xFFFE, `cout`=0, `ovf`=0.
  - 0x8000 − 0x0001 → `sum`=0x7FFF, `cout`=1, `ovf`=1.
  - First `cla_cin`=1 in both.
- Handshake: `start` with new operands in cycle 2 (during RUN) is ignored and the result equals the first op. A `start` asserted in the DONE cycle (A=0x0001, B=0x0001) gives RUN in cycles 6–9 and `done` in cycle 10 with `sum`=0x0002.
- Reset mid-op: `rst` in cycle 3 of an add → next cycle IDLE, all outputs at reset values, no `done` pulse. A new `start` afterwards completes normally.
